// File: rtl/sync_scheduler.sv
// Sync pulse scheduler: walks a programmable interval table, one pulse per scheduled second tick.
// Optional macro SYNC_SCHED_STAMP_EN adds stamp_sec/stamp_idx/stamp_vld pulse-start stamps.
`timescale 1ns/1ps
module sync_scheduler #(
    parameter int unsigned FS            = 25000,
    parameter int unsigned PULSE_FRAMES  = 2500,
    parameter int unsigned NUM_INTERVALS = 8,
    parameter int unsigned IW            = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             frame_pulse,
    input  logic                             sec_vld,
    input  logic [11:0]                      sec,
    output logic                             sec_rdy,
    input  logic                             enable,
    input  logic                             cfg_we,
    input  logic [$clog2(NUM_INTERVALS)-1:0] cfg_addr,
    input  logic [IW-1:0]                    cfg_data,
    output logic                             sync_pulse,
    output logic [$clog2(NUM_INTERVALS)-1:0] pulse_idx,
    output logic                             busy
`ifdef SYNC_SCHED_STAMP_EN
    ,
    output logic [11:0]                      stamp_sec,
    output logic [$clog2(NUM_INTERVALS)-1:0] stamp_idx,
    output logic                             stamp_vld
`endif
);

    localparam int unsigned AW  = $clog2(NUM_INTERVALS);
    localparam int unsigned FCW = $clog2(FS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]     r_state;
    logic           r_sync;
    logic           r_busy;
    logic           r_sec_rdy;
    logic [AW-1:0]  r_idx;
    logic [IW-1:0]  r_ivl;
    logic [IW-1:0]  r_sc;
    logic [FCW-1:0] r_fc;
    logic           r_pend;
    logic [IW-1:0]  r_table [NUM_INTERVALS];

    logic [1:0]     w_state_nx;
    logic           w_sync_nx;
    logic [AW-1:0]  w_idx_nx;
    logic [IW-1:0]  w_ivl_nx;
    logic [IW-1:0]  w_sc_nx;
    logic [FCW-1:0] w_fc_nx;
    logic           w_pend_nx;

    logic           w_tick;
    logic [IW-1:0]  w_sc_inc;
    logic           w_ivl_hit;
    logic [FCW-1:0] w_fc_inc;
    logic           w_last_frame;
    logic [AW-1:0]  w_idx_inc;
    logic [IW-1:0]  w_ivl_first;
    logic [IW-1:0]  w_ivl_next;

    // Schedule arithmetic; zero table entries behave as a one-second interval
    assign w_tick       = sec_vld & r_sec_rdy;
    assign w_sc_inc     = (r_sc == {IW{1'b1}}) ? r_sc : r_sc + IW'(1);
    assign w_ivl_hit    = ({1'b0, r_sc} + (IW+1)'(1)) >= {1'b0, r_ivl};
    assign w_fc_inc     = r_fc + FCW'(1);
    assign w_last_frame = frame_pulse && (w_fc_inc == FCW'(PULSE_FRAMES));
    assign w_idx_inc    = r_idx + AW'(1);
    assign w_ivl_first  = (r_table[0] == '0) ? IW'(1) : r_table[0];
    assign w_ivl_next   = (r_table[w_idx_inc] == '0) ? IW'(1) : r_table[w_idx_inc];

    always_comb begin
        w_state_nx = r_state;
        w_sync_nx  = r_sync;
        w_idx_nx   = r_idx;
        w_ivl_nx   = r_ivl;
        w_sc_nx    = r_sc;
        w_fc_nx    = r_fc;
        w_pend_nx  = r_pend;
        case (r_state)
            S_IDLE: begin
                w_sync_nx = 1'b0;
                if (enable) w_state_nx = S_ARM;
            end
            S_ARM: begin
                if (w_tick) begin
                    w_state_nx = S_PULSE;
                    w_sync_nx  = 1'b1;
                    w_idx_nx   = '0;
                    w_ivl_nx   = w_ivl_first;
                    w_sc_nx    = '0;
                    w_fc_nx    = '0;
                end
            end
            S_PULSE: begin
                if (frame_pulse) w_fc_nx = w_fc_inc;
                // A due interval during the pulse is remembered and served after a one-cycle gap
                if (w_tick) begin
                    w_sc_nx = w_sc_inc;
                    if (w_ivl_hit) w_pend_nx = 1'b1;
                end
                if (w_last_frame) begin
                    w_state_nx = S_WAIT;
                    w_sync_nx  = 1'b0;
                end
            end
            default: begin
                if (r_pend || (w_tick && w_ivl_hit)) begin
                    w_state_nx = S_PULSE;
                    w_sync_nx  = 1'b1;
                    w_idx_nx   = w_idx_inc;
                    w_ivl_nx   = w_ivl_next;
                    w_sc_nx    = '0;
                    w_fc_nx    = '0;
                    w_pend_nx  = 1'b0;
                end else if (w_tick) begin
                    w_sc_nx = w_sc_inc;
                end
            end
        endcase
        if (!enable && (r_state != S_IDLE)) begin
            w_state_nx = S_IDLE;
            w_sync_nx  = 1'b0;
            w_idx_nx   = '0;
            w_sc_nx    = '0;
            w_fc_nx    = '0;
            w_pend_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sync    <= 1'b0;
            r_busy    <= 1'b0;
            r_sec_rdy <= 1'b0;
            r_idx     <= '0;
            r_ivl     <= IW'(1);
            r_sc      <= '0;
            r_fc      <= '0;
            r_pend    <= 1'b0;
            for (int unsigned i = 0; i < NUM_INTERVALS; i++) r_table[i] <= IW'(1);
        end else begin
            r_state   <= w_state_nx;
            r_sync    <= w_sync_nx;
            r_busy    <= (w_state_nx != S_IDLE);
            r_sec_rdy <= 1'b1;
            r_idx     <= w_idx_nx;
            r_ivl     <= w_ivl_nx;
            r_sc      <= w_sc_nx;
            r_fc      <= w_fc_nx;
            r_pend    <= w_pend_nx;
            if (cfg_we) r_table[cfg_addr] <= cfg_data;
        end
    end

    assign sec_rdy    = r_sec_rdy;
    assign sync_pulse = r_sync;
    assign pulse_idx  = r_idx;
    assign busy       = r_busy;

`ifdef SYNC_SCHED_STAMP_EN
    logic          r_stamp_vld;
    logic [11:0]   r_stamp_sec;
    logic [AW-1:0] r_stamp_idx;
    logic [11:0]   r_pend_sec;
    logic          w_start;
    logic          w_pend_set;

    // Every pulse start is a rising edge of sync_pulse (pulses are always separated by a low cycle)
    assign w_start    = w_sync_nx & ~r_sync;
    assign w_pend_set = (r_state == S_PULSE) && w_tick && w_ivl_hit && !r_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stamp_vld <= 1'b0;
            r_stamp_sec <= '0;
            r_stamp_idx <= '0;
            r_pend_sec  <= '0;
        end else begin
            r_stamp_vld <= w_start;
            if (w_start) begin
                r_stamp_sec <= r_pend ? r_pend_sec : sec;
                r_stamp_idx <= w_idx_nx;
            end
            if (w_pend_set) r_pend_sec <= sec;
        end
    end

    assign stamp_vld = r_stamp_vld;
    assign stamp_sec = r_stamp_sec;
    assign stamp_idx = r_stamp_idx;
`else
    logic w_unused;
    assign w_unused = ^sec;
`endif

endmodule

// File: tb/tb_sync_scheduler.sv
// Self-checking bench for sync_scheduler: directed tick tables plus randomized run vs. a behavioural model.
`timescale 1ns/1ps
module tb_sync_scheduler;

    localparam int PF = 4;
    localparam int NI = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_pulse = 1'b0;
    logic        sec_vld = 1'b0;
    logic [11:0] sec = '0;
    logic        sec_rdy;
    logic        enable = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic        sync_pulse;
    logic [2:0]  pulse_idx;
    logic        busy;
`ifdef SYNC_SCHED_STAMP_EN
    logic [11:0] stamp_sec;
    logic [2:0]  stamp_idx;
    logic        stamp_vld;
`endif

    sync_scheduler #(
        .FS(25000), .PULSE_FRAMES(PF), .NUM_INTERVALS(NI), .IW(8)
    ) dut (
        .clk(clk), .rst(rst), .frame_pulse(frame_pulse), .sec_vld(sec_vld), .sec(sec),
        .sec_rdy(sec_rdy), .enable(enable), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .sync_pulse(sync_pulse), .pulse_idx(pulse_idx), .busy(busy)
`ifdef SYNC_SCHED_STAMP_EN
        , .stamp_sec(stamp_sec), .stamp_idx(stamp_idx), .stamp_vld(stamp_vld)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural model: "is a pulse on", "how many frames seen", "seconds since start", "due"
    bit          m_rdy, m_active, m_started, m_on, m_due, m_svld;
    int          m_idx, m_sc, m_ivl, m_frames, m_sidx;
    int          m_tbl [NI];
    logic [11:0] m_due_sec, m_ssec;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic begin_pulse(input int i, input logic [11:0] s);
        m_idx    = i % NI;
        m_ivl    = (m_tbl[m_idx] == 0) ? 1 : m_tbl[m_idx];
        m_sc     = 0;
        m_frames = 0;
        m_on     = 1;
        m_due    = 0;
        m_svld   = 1;
        m_ssec   = s;
        m_sidx   = m_idx;
    endtask

    task automatic model_edge();
        bit tick;
        if (rst) begin
            m_rdy = 0; m_active = 0; m_started = 0; m_on = 0; m_due = 0; m_svld = 0;
            m_idx = 0; m_sc = 0; m_frames = 0; m_ivl = 1; m_sidx = 0; m_ssec = '0; m_due_sec = '0;
            for (int i = 0; i < NI; i++) m_tbl[i] = 1;
            return;
        end
        tick   = sec_vld && m_rdy;
        m_svld = 0;
        if (!m_active) begin
            if (enable) m_active = 1;
        end else if (!enable) begin
            m_active = 0; m_started = 0; m_on = 0; m_due = 0;
            m_idx = 0; m_sc = 0; m_frames = 0;
        end else if (!m_started) begin
            if (tick) begin
                m_started = 1;
                begin_pulse(0, sec);
            end
        end else if (m_on) begin
            if (tick) begin
                m_sc = (m_sc < 255) ? m_sc + 1 : 255;
                if (m_sc >= m_ivl && !m_due) begin
                    m_due     = 1;
                    m_due_sec = sec;
                end
            end
            if (frame_pulse) begin
                m_frames++;
                if (m_frames == PF) m_on = 0;
            end
        end else begin
            if (m_due) begin
                begin_pulse(m_idx + 1, m_due_sec);
            end else if (tick) begin
                m_sc = (m_sc < 255) ? m_sc + 1 : 255;
                if (m_sc >= m_ivl) begin_pulse(m_idx + 1, sec);
            end
        end
        m_rdy = 1;
        if (cfg_we) m_tbl[cfg_addr] = int'(cfg_data);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", {26'd0, sync_pulse, pulse_idx, busy, sec_rdy},
              {26'd0, m_on, 3'(m_idx), m_active, m_rdy});
`ifdef SYNC_SCHED_STAMP_EN
        check("model_stamp", {16'd0, stamp_vld, stamp_idx, stamp_sec},
              {16'd0, m_svld, 3'(m_sidx), m_ssec});
`endif
        cyc++;
    endtask

    task automatic run_gap(input int n);
        for (int k = 0; k < n; k++) begin
            frame_pulse = (cyc % 10 == 1);
            sec_vld     = 1'b0;
            cfg_we      = 1'b0;
            step();
        end
    endtask

    task automatic send_tick(input logic [11:0] s);
        frame_pulse = (cyc % 10 == 1);
        sec_vld     = 1'b1;
        sec         = s;
        cfg_we      = 1'b0;
        step();
        sec_vld     = 1'b0;
    endtask

    task automatic tick_at(input int target, input logic [11:0] s);
        if (target > cyc) run_gap(target - cyc);
        send_tick(s);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        frame_pulse = (cyc % 10 == 1);
        sec_vld     = 1'b0;
        cfg_we      = 1'b1;
        cfg_addr    = a;
        cfg_data    = d;
        step();
        cfg_we      = 1'b0;
    endtask

    typedef struct {
        logic [11:0] sec;
        logic        exp_rise;
        logic [2:0]  exp_idx;
        logic        wr;
        logic [2:0]  waddr;
        logic [7:0]  wdata;
    } vec_t;

    vec_t        vecs [21];
    logic [7:0]  tbl_init [NI];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : main
        int w;
        int base;
        bit fell;

        // Table {1,3,2,1,1,1,1,1}; entry 2 rewritten to 5 while pulse idx 2 waits
        tbl_init = '{8'd1, 8'd3, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        vecs[0]  = '{12'd100, 1'b1, 3'd0, 1'b0, 3'd0, 8'd0};
        vecs[1]  = '{12'd101, 1'b1, 3'd1, 1'b0, 3'd0, 8'd0};
        vecs[2]  = '{12'd102, 1'b0, 3'd1, 1'b0, 3'd0, 8'd0};
        vecs[3]  = '{12'd103, 1'b0, 3'd1, 1'b0, 3'd0, 8'd0};
        vecs[4]  = '{12'd104, 1'b1, 3'd2, 1'b1, 3'd2, 8'd5};
        vecs[5]  = '{12'd105, 1'b0, 3'd2, 1'b0, 3'd0, 8'd0};
        vecs[6]  = '{12'd7,   1'b1, 3'd3, 1'b0, 3'd0, 8'd0};
        vecs[7]  = '{12'd107, 1'b1, 3'd4, 1'b0, 3'd0, 8'd0};
        vecs[8]  = '{12'd108, 1'b1, 3'd5, 1'b0, 3'd0, 8'd0};
        vecs[9]  = '{12'd109, 1'b1, 3'd6, 1'b0, 3'd0, 8'd0};
        vecs[10] = '{12'd110, 1'b1, 3'd7, 1'b0, 3'd0, 8'd0};
        vecs[11] = '{12'd111, 1'b1, 3'd0, 1'b0, 3'd0, 8'd0};
        vecs[12] = '{12'd112, 1'b1, 3'd1, 1'b0, 3'd0, 8'd0};
        vecs[13] = '{12'd113, 1'b0, 3'd1, 1'b0, 3'd0, 8'd0};
        vecs[14] = '{12'd114, 1'b0, 3'd1, 1'b0, 3'd0, 8'd0};
        vecs[15] = '{12'd115, 1'b1, 3'd2, 1'b0, 3'd0, 8'd0};
        vecs[16] = '{12'd116, 1'b0, 3'd2, 1'b0, 3'd0, 8'd0};
        vecs[17] = '{12'd117, 1'b0, 3'd2, 1'b0, 3'd0, 8'd0};
        vecs[18] = '{12'd118, 1'b0, 3'd2, 1'b0, 3'd0, 8'd0};
        vecs[19] = '{12'd119, 1'b0, 3'd2, 1'b0, 3'd0, 8'd0};
        vecs[20] = '{12'd120, 1'b1, 3'd3, 1'b0, 3'd0, 8'd0};

        // Reset state
        rst = 1'b1;
        run_gap(3);
        check("reset_outputs", {26'd0, sync_pulse, pulse_idx, busy, sec_rdy}, 32'd0);

        // Default table, first tick at cycle 500
        rst    = 1'b0;
        enable = 1'b1;
        cyc    = 0;
        run_gap(1);
        check("rdy_after_reset", {31'd0, sec_rdy}, 32'd1);
        check("arm_busy", {31'd0, busy}, 32'd1);
        run_gap(499);
        check("armed_low", {31'd0, sync_pulse}, 32'd0);
        send_tick(12'd50);
        check("first_rise", {31'd0, sync_pulse}, 32'd1);
        check("first_idx", {29'd0, pulse_idx}, 32'd0);
        w = 1;
        for (int k = 0; k < 100; k++) begin
            run_gap(1);
            if (!sync_pulse) break;
            w++;
        end
        check("pulse_width", w, 32'd31);
        tick_at(900, 12'd51);
        check("dflt_rise1", {28'd0, sync_pulse, pulse_idx}, {28'd0, 1'b1, 3'd1});
        tick_at(1300, 12'd52);
        check("dflt_rise2", {28'd0, sync_pulse, pulse_idx}, {28'd0, 1'b1, 3'd2});

        // Program the table while disabled, then run the tick vectors
        run_gap(50);
        enable = 1'b0;
        run_gap(1);
        check("disabled", {28'd0, busy, pulse_idx}, 32'd0);
        for (int i = 0; i < NI; i++) cfg_write(3'(i), tbl_init[i]);
        enable = 1'b1;
        run_gap(1);
        base = cyc + 400;
        for (int i = 0; i < 21; i++) begin
            tick_at(base + 400 * i, vecs[i].sec);
            check("vec_rise", {31'd0, sync_pulse}, {31'd0, vecs[i].exp_rise});
            check("vec_idx", {29'd0, pulse_idx}, {29'd0, vecs[i].exp_idx});
`ifdef SYNC_SCHED_STAMP_EN
            if (vecs[i].exp_rise)
                check("vec_stamp", {16'd0, stamp_vld, stamp_idx, stamp_sec},
                      {16'd0, 1'b1, vecs[i].exp_idx, vecs[i].sec});
`endif
            if (vecs[i].wr) begin
                run_gap(3);
                cfg_write(vecs[i].waddr, vecs[i].wdata);
            end
        end

        // Disable mid-pulse, then re-arm
        run_gap(5);
        check("mid_pulse_high", {31'd0, sync_pulse}, 32'd1);
        enable = 1'b0;
        run_gap(1);
        check("disable_mid", {27'd0, sync_pulse, busy, pulse_idx}, 32'd0);
        enable = 1'b1;
        run_gap(1);
        check("rearm_busy", {31'd0, busy}, 32'd1);
        tick_at(cyc + 50, 12'd200);
        check("rearm_rise", {28'd0, sync_pulse, pulse_idx}, {28'd0, 1'b1, 3'd0});

        // Tick during a pulse with interval 1: one low cycle then the next pulse
        run_gap(5);
        send_tick(12'd7);
        check("pend_still_high", {31'd0, sync_pulse}, 32'd1);
        fell = 1'b0;
        for (int k = 0; k < 200; k++) begin
            run_gap(1);
            if (!sync_pulse) begin
                fell = 1'b1;
                break;
            end
        end
        check("pend_fall", {31'd0, fell}, 32'd1);
        run_gap(1);
        check("pend_gap1", {28'd0, sync_pulse, pulse_idx}, {28'd0, 1'b1, 3'd1});
`ifdef SYNC_SCHED_STAMP_EN
        check("pend_stamp", {16'd0, stamp_vld, stamp_idx, stamp_sec}, {16'd0, 1'b1, 3'd1, 12'd7});
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 20000; n++) begin
            rst = ($urandom_range(0, 2999) == 0);
            if (enable) begin
                if ($urandom_range(0, 499) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                enable = 1'b1;
            end
            frame_pulse = ($urandom_range(0, 2) == 0);
            sec_vld     = ($urandom_range(0, 9) == 0);
            sec         = 12'($urandom);
            cfg_we      = ($urandom_range(0, 59) == 0);
            cfg_addr    = 3'($urandom);
            cfg_data    = 8'($urandom_range(0, 4));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_scheduler.md
Name: sync_scheduler

Overview:
- Sequences the sync pulse train sent to the behaviour box.
- Consumes the per-second time stream (seconds counter plus valid) derived from frame counting.
- Steps through a programmable table of inter-pulse intervals, in seconds.
- Drives sync_pulse high for a fixed number of frames at each scheduled second.
- Replaces the fixed-pattern generator, so host software can reprogram the barcode sequence without a rebuild.

Parameters:
- FS, 25000, frames per second (documentation and bound checking only).
- PULSE_FRAMES, 2500, pulse width in frame_pulse events (100 ms at FS). Constraint: 1 <= PULSE_FRAMES < FS.
- NUM_INTERVALS, 8, interval table depth. Power of two, 2..16.
- IW, 8, interval entry width in seconds.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset (!SPI_running)
- frame_pulse  in  1  one-cycle strobe per sample frame
- sec_vld  in  1  seconds-tick valid
- sec  in  12  seconds count accompanying sec_vld
- sec_rdy  out  1  tick ready; a tick is accepted when sec_vld && sec_rdy
- enable  in  1  schedule run enable
- cfg_we  in  1  interval table write strobe
- cfg_addr  in  log2(NUM_INTERVALS)  table index
- cfg_data  in  IW  interval in seconds
- sync_pulse  out  1  pulse to behaviour box (registered)
- pulse_idx  out  log2(NUM_INTERVALS)  table index of the current or next pulse
- busy  out  1  high in ARM, PULSE or WAIT

Behaviour:
- Reset values:
  - sync_pulse=0, pulse_idx=0, busy=0, sec_rdy=0, state=IDLE.
  - Seconds counter sc=0, frame counter fc=0, pending=0.
  - Table entries reset to 1.
- sec_rdy is 1 from the first cycle after reset release. The block never backpressures.
- Table writes:
  - Honoured in every state. Write takes effect the cycle after cfg_we.
  - The interval for pulse k is latched into ivl at the start of pulse k. A later write to entry k does not affect the current wait.
  - Entry value 0 is treated as 1.
- IDLE:
  - sync_pulse=0.
  - enable=1 -> ARM.
- ARM:
  - Wait for the first accepted tick (any sec value).
  - On that tick: enter PULSE next cycle, sync_pulse=1, idx=0, ivl=max(table[0],1), sc=0, fc=0.
- PULSE:
  - sync_pulse=1.
  - fc increments on each frame_pulse. The frame_pulse in the entry cycle is counted.
  - When fc reaches PULSE_FRAMES, sync_pulse=0 next cycle and the state moves to WAIT.
  - Accepted ticks increment sc (saturating at 2^IW-1).
- WAIT:
  - An accepted tick increments sc.
  - When sc+1 >= ivl on a tick: idx advances modulo NUM_INTERVALS and the state moves to PULSE next cycle.
  - On that transition, ivl=max(table[new idx],1), sc=0, fc=0.
- Latency: accepted tick on cycle N -> sync_pulse rises on cycle N+1.
- Interval condition met during PULSE:
  - Set pending.
  - On pulse end, sync_pulse is low for exactly one cycle, then the next pulse starts. pending clears.
- Tick and final frame_pulse in the same cycle: the tick counts toward sc. The pulse ends normally.
- enable=0 in any non-IDLE state:
  - Next cycle: state=IDLE, sync_pulse=0, idx=0, sc=0, fc=0, pending=0.
  - Table contents are kept.
- rst during operation: all state returns to reset values on the next edge, including table entries reset to 1.
- sec data is not used for scheduling (ticks only) except under the optional feature.

Optional Feature:
- Macro: SYNC_SCHED_STAMP_EN.
- When defined, add ports stamp_sec (out, 12), stamp_idx (out, log2(NUM_INTERVALS)) and stamp_vld (out, 1).
  - On each pulse start, capture the sec value of the tick that triggered it, plus idx.
  - stamp_vld is a one-cycle strobe, coincident with the sync_pulse rising edge.
  - For a pending-started pulse, stamp_sec is the tick that set pending.
  - All three outputs reset to 0.
- When undefined, these ports and registers do not exist. Behaviour is otherwise identical.

Test Plan:
- Bench configuration for all cases: PULSE_FRAMES=4, frame_pulse every 10 cycles, ticks every 40 frames.
- Reset then enable=1 with default table; first tick at cycle 500 -> sync_pulse high cycles 501..~531 (4 frames); next pulse at the following tick (interval 1); pulse_idx 0,1,2...
- Write table={1,3,2,...}, run -> rising edges at ticks 0, 1, 4, 6; idx wraps from 7 to 0 after eight pulses.
- Write table[2]=5 while idx=2 is waiting -> current wait unchanged; the next use of entry 2 waits 5 ticks.
- Deassert enable mid-pulse -> sync_pulse=0 the next cycle, busy=0, pulse_idx=0. Re-enable -> ARM; first tick gives idx 0.
- Tick forced during PULSE with ivl=1 -> pending set; after the pulse ends, sync_pulse is low for exactly 1 cycle, then high again.
- With SYNC_SCHED_STAMP_EN and sec=7 on the trigger tick -> stamp_vld pulses for 1 cycle with stamp_sec=7 and stamp_idx equal to the current idx.
